quiz_round_ctrl: RTL

Round sequencer for the arithmetic quiz game.
- Generates an operand pair and operator from an internal LFSR and computes the expected result.
- Presents the question to the 7-segment display datapath, then waits for the player's one-hot operator switch or a timeout.
- Scores the round, saturating the score, and drives a timed motor reward or penalty pulse.
- Sits between the player inputs (start button, switches) and the display/motor drivers.

---
 rtl/quiz_pkg.sv | 29 ++
 rtl/quiz_lfsr16.sv | 26 ++
 rtl/quiz_round_ctrl.sv | 251 +++++++++++++++++++++++++
 3 files changed

// File: rtl/quiz_pkg.sv
// Shared types and encodings for the arithmetic quiz round sequencer.
package quiz_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    GEN     = 3'd1,
    CALC    = 3'd2,
    ASK     = 3'd3,
    REWARD  = 3'd4,
    PENALTY = 3'd5
  } state_t;

  localparam logic [1:0] OP_ADD = 2'd0;
  localparam logic [1:0] OP_SUB = 2'd1;
  localparam logic [1:0] OP_MUL = 2'd2;
  localparam logic [1:0] OP_DIV = 2'd3;

  localparam logic [1:0] MOTOR_STOP = 2'b00;
  localparam logic [1:0] MOTOR_FWD  = 2'b01;
  localparam logic [1:0] MOTOR_REV  = 2'b10;

  localparam logic [15:0] LFSR_MASK = 16'hB400;

  // Map a raw nibble onto a decimal digit: 10..15 fold down to 4..9.
  function automatic logic [3:0] fold_digit(input logic [3:0] v);
    return (v > 4'd9) ? (v - 4'd6) : v;
  endfunction

endpackage

// File: rtl/quiz_lfsr16.sv
// Free-running 16-bit Galois LFSR used as the question source.
module quiz_lfsr16
  import quiz_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] seed,
  output logic [15:0] q
);

  logic [15:0] r_lfsr;

  // Load the seed in reset, otherwise shift right and fold in the taps
  always_ff @(posedge clk) begin
    if (reset) begin
      r_lfsr <= seed;
    end else if (r_lfsr[0]) begin
      r_lfsr <= (r_lfsr >> 1) ^ LFSR_MASK;
    end else begin
      r_lfsr <= r_lfsr >> 1;
    end
  end

  assign q = r_lfsr;

endmodule

// File: rtl/quiz_round_ctrl.sv
// Quiz round sequencer: question generation, answer/timeout handling,
// saturating score and timed motor reward/penalty pulse.
//
// state   | meaning
// IDLE    | waiting for a start-button edge
// GEN     | latch operands and operator from the LFSR
// CALC    | compute the expected result
// ASK     | question shown, waiting for an armed answer or timeout
// REWARD  | motor forward for MOTOR_CYCLES, score already incremented
// PENALTY | motor reverse for MOTOR_CYCLES, score already decremented
module quiz_round_ctrl
  import quiz_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 50_000_000,
  parameter int unsigned MOTOR_CYCLES   = 25_000_000,
  parameter int unsigned MAX_POINTS     = 9,
  parameter logic [15:0] LFSR_SEED      = 16'hACE1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start_i,
  input  logic [3:0] answer_i,
  output logic [3:0] num1_o,
  output logic [3:0] num2_o,
  output logic [1:0] op_o,
  output logic [6:0] result_o,
  output logic       q_valid_o,
  output logic [3:0] point_o,
  output logic [1:0] motor_o,
  output logic       timeout_o,
  output logic       game_over_o
);

  localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam int MW = (MOTOR_CYCLES > 1) ? $clog2(MOTOR_CYCLES) : 1;
  localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [MW-1:0] MO_LAST = MW'(MOTOR_CYCLES - 1);
  localparam logic [3:0]    PT_MAX  = 4'(MAX_POINTS);

  state_t        r_state;
  state_t        w_state_nxt;
  logic [15:0]   w_lfsr;
  logic          w_unused_lfsr;
  logic          r_start_q;
  logic          w_start_edge;

  logic [3:0]    w_a;
  logic [3:0]    w_b;
  logic [1:0]    w_op;
  logic [3:0]    w_hi;
  logic [3:0]    w_lo;

  logic [3:0]    r_num1;
  logic [3:0]    r_num2;
  logic [1:0]    r_op;
  logic [6:0]    r_result;
  logic [6:0]    w_n1x;
  logic [6:0]    w_n2x;
  logic [6:0]    w_result;

  logic [TW-1:0] r_to_cnt;
  logic          r_armed;
  logic [MW-1:0] r_mo_cnt;
  logic [3:0]    w_op_onehot;

  logic [3:0]    r_point;
  logic [3:0]    w_point_nxt;
  logic [3:0]    w_point_inc;
  logic [3:0]    w_point_dec;
  logic          r_game_over;
  logic [1:0]    r_motor;
  logic [1:0]    w_motor_nxt;
  logic          r_timeout;
  logic          w_timeout_hit;

  quiz_lfsr16 u_lfsr (
    .clk   (clk),
    .reset (reset),
    .seed  (LFSR_SEED),
    .q     (w_lfsr)
  );

  // Only the low ten LFSR bits feed the question.
  assign w_unused_lfsr = ^w_lfsr[15:10];

  assign w_start_edge = start_i & ~r_start_q;
  assign w_a          = fold_digit(w_lfsr[3:0]);
  assign w_b          = fold_digit(w_lfsr[7:4]);
  assign w_op         = w_lfsr[9:8];
  assign w_n1x        = {3'b000, r_num1};
  assign w_n2x        = {3'b000, r_num2};
  assign w_op_onehot  = 4'b0001 << r_op;
  assign w_point_inc  = (r_point >= PT_MAX) ? PT_MAX : (r_point + 4'd1);
  assign w_point_dec  = (r_point == 4'd0) ? 4'd0 : (r_point - 4'd1);

  // Order the operands larger-first and keep division away from zero
  always_comb begin
    w_hi = w_a;
    w_lo = w_b;
    if (w_b > w_a) begin
      w_hi = w_b;
      w_lo = w_a;
    end
    if ((w_op == OP_DIV) && (w_lo == 4'd0)) begin
      w_lo = 4'd1;
    end
  end

  // Expected result from the latched question; SUB cannot go negative
  always_comb begin
    w_result = 7'd0;
    case (r_op)
      OP_ADD:  w_result = w_n1x + w_n2x;
      OP_SUB:  w_result = w_n1x - w_n2x;
      OP_MUL:  w_result = w_n1x * w_n2x;
      default: w_result = (r_num2 == 4'd0) ? 7'd0 : (w_n1x / w_n2x);
    endcase
  end

  // Next state, next score, motor code and timeout pulse
  always_comb begin
    w_state_nxt   = r_state;
    w_point_nxt   = r_point;
    w_timeout_hit = 1'b0;
    w_motor_nxt   = MOTOR_STOP;
    case (r_state)
      IDLE: begin
        if (w_start_edge) begin
          w_state_nxt = GEN;
          if (r_game_over) begin
            w_point_nxt = 4'd0;
          end
        end
      end
      GEN:  w_state_nxt = CALC;
      CALC: w_state_nxt = ASK;
      ASK: begin
        // An accepted answer takes priority over an expiring timer.
        if (r_armed && (answer_i != 4'd0)) begin
          if (answer_i == w_op_onehot) begin
            w_state_nxt = REWARD;
            w_point_nxt = w_point_inc;
          end else begin
            w_state_nxt = PENALTY;
            w_point_nxt = w_point_dec;
          end
        end else if (r_to_cnt == TO_LAST) begin
          w_state_nxt   = PENALTY;
          w_point_nxt   = w_point_dec;
          w_timeout_hit = 1'b1;
        end
      end
      REWARD, PENALTY: begin
        if (r_mo_cnt == MO_LAST) begin
          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
    if (w_state_nxt == REWARD) begin
      w_motor_nxt = MOTOR_FWD;
    end else if (w_state_nxt == PENALTY) begin
      w_motor_nxt = MOTOR_REV;
    end
  end

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Previous start-button level for edge detection
  always_ff @(posedge clk) begin
    if (reset) begin
      r_start_q <= 1'b0;
    end else begin
      r_start_q <= start_i;
    end
  end

  // Question registers: operands in GEN, result in CALC, held otherwise
  always_ff @(posedge clk) begin
    if (reset) begin
      r_num1   <= 4'd0;
      r_num2   <= 4'd0;
      r_op     <= OP_ADD;
      r_result <= 7'd0;
    end else begin
      if (r_state == GEN) begin
        r_num1 <= w_hi;
        r_num2 <= w_lo;
        r_op   <= w_op;
      end
      if (r_state == CALC) begin
        r_result <= w_result;
      end
    end
  end

  // ASK timer and arming; the first idle-switch cycle arms the answer
  always_ff @(posedge clk) begin
    if (reset || (r_state != ASK)) begin
      r_to_cnt <= '0;
      r_armed  <= 1'b0;
    end else begin
      r_to_cnt <= r_to_cnt + 1'b1;
      if (answer_i == 4'd0) begin
        r_armed <= 1'b1;
      end
    end
  end

  // Motor hold timer, counting cycles spent in REWARD or PENALTY
  always_ff @(posedge clk) begin
    if (reset || ((r_state != REWARD) && (r_state != PENALTY))) begin
      r_mo_cnt <= '0;
    end else begin
      r_mo_cnt <= r_mo_cnt + 1'b1;
    end
  end

  // Registered score, game-over flag, motor drive and timeout pulse
  always_ff @(posedge clk) begin
    if (reset) begin
      r_point     <= 4'd0;
      r_game_over <= 1'b0;
      r_motor     <= MOTOR_STOP;
      r_timeout   <= 1'b0;
    end else begin
      r_point     <= w_point_nxt;
      r_game_over <= (w_point_nxt == PT_MAX);
      r_motor     <= w_motor_nxt;
      r_timeout   <= w_timeout_hit;
    end
  end

  assign num1_o      = r_num1;
  assign num2_o      = r_num2;
  assign op_o        = r_op;
  assign result_o    = r_result;
  assign q_valid_o   = (r_state == ASK);
  assign point_o     = r_point;
  assign motor_o     = r_motor;
  assign timeout_o   = r_timeout;
  assign game_over_o = r_game_over;

endmodule
